// File: rtl/vram_arbiter_pkg.sv
// rtl/vram_arbiter_pkg.sv - VRAM arbiter constants, state codes and read-owner tag
package vram_arbiter_pkg;
`include "vram_defs.vh"

  localparam int VRAM_ADDR_W = `VRAM_ADDR_W;
  localparam int VRAM_DATA_W = `VRAM_DATA_W;

  localparam logic [1:0] ST_IDLE  = `VRAM_ST_IDLE;
  localparam logic [1:0] ST_PEND  = `VRAM_ST_PEND;
  localparam logic [1:0] ST_CLEAR = `VRAM_ST_CLEAR;

  // Who the RAM read data launched this cycle belongs to
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;
endpackage

// File: rtl/vram_defs.vh
// rtl/vram_defs.vh - shared VRAM geometry and arbiter state encodings
`ifndef VRAM_DEFS_VH
`define VRAM_DEFS_VH

`define VRAM_ADDR_W   11
`define VRAM_DATA_W   8

`define VRAM_ST_IDLE  2'd0
`define VRAM_ST_PEND  2'd1
`define VRAM_ST_CLEAR 2'd2

`endif

// File: rtl/vram_store.sv
// rtl/vram_store.sv - single-port synchronous VRAM, read data registered on en
module vram_store #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              en,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - shares the VRAM port between video fetch, CPU and clear engine
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int    ADDR_W    = VRAM_ADDR_W,
  parameter int    DATA_W    = VRAM_DATA_W,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              vid_strobe,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              clear_start,
  output logic              clear_done
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] p_addr;
  logic              p_we;
  logic [DATA_W-1:0] p_wdata;
  logic [ADDR_W-1:0] clr_cnt;
  owner_t            owner_q, owner_d;
  logic [DATA_W-1:0] vid_hold, cpu_hold;
  logic              done_q;

  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  logic accept, pend_go, clr_go, clr_last;

  // Reset blocks pending/clear writes so an abort leaves RAM untouched that cycle
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = vid_addr;
    ram_wdata = '0;
    owner_d   = OWN_NONE;
    accept    = !reset && state == ST_IDLE && cpu_req && !clear_start;
    pend_go   = !reset && state == ST_PEND && !vid_strobe;
    clr_go    = !reset && state == ST_CLEAR && !vid_strobe;
    clr_last  = clr_go && clr_cnt == {ADDR_W{1'b1}};
    if (vid_strobe) begin
      ram_en  = 1'b1;
      owner_d = OWN_VID;
    end else if (pend_go) begin
      ram_en    = 1'b1;
      ram_we    = p_we;
      ram_addr  = p_addr;
      ram_wdata = p_wdata;
      owner_d   = p_we ? OWN_NONE : OWN_CPU;
    end else if (clr_go) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = clr_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      p_addr   <= '0;
      p_we     <= 1'b0;
      p_wdata  <= '0;
      clr_cnt  <= '0;
      owner_q  <= OWN_NONE;
      vid_hold <= '0;
      cpu_hold <= '0;
      done_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      done_q  <= clr_last;
      if (owner_q == OWN_VID) vid_hold <= ram_rdata;
      if (owner_q == OWN_CPU) cpu_hold <= ram_rdata;
      case (state)
        ST_IDLE: begin
          if (clear_start) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end else if (accept) begin
            state   <= ST_PEND;
            p_addr  <= cpu_addr;
            p_we    <= cpu_we;
            p_wdata <= cpu_wdata;
          end
        end
        ST_PEND: begin
          if (pend_go) state <= ST_IDLE;
        end
        ST_CLEAR: begin
          if (clr_go) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_last) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Fresh read data is passed straight through; afterwards the captured copy holds it
  assign vid_data   = (owner_q == OWN_VID) ? ram_rdata : vid_hold;
  assign cpu_rdata  = (owner_q == OWN_CPU) ? ram_rdata : cpu_hold;
  assign cpu_rvalid = (owner_q == OWN_CPU);
  assign cpu_busy   = (state != ST_IDLE);
  assign clear_done = done_q;

  vram_store #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_store (
    .clk  (clk),
    .addr (ram_addr),
    .we   (ram_we),
    .wdata(ram_wdata),
    .en   (ram_en),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] vid_addr;
  logic        vid_strobe;
  logic [7:0]  vid_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_busy;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        clear_start;
  logic        clear_done;

  int vectors = 0;
  int miscompares = 0;

  vram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .vid_addr   (vid_addr),
    .vid_strobe (vid_strobe),
    .vid_data   (vid_data),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_busy   (cpu_busy),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .clear_start(clear_start),
    .clear_done (clear_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk("wr_busy", {31'd0, cpu_busy}, 32'd1);
    tick();
    chk("wr_idle", {31'd0, cpu_busy}, 32'd0);
  endtask

  task automatic vid_read(input logic [10:0] a, input logic [7:0] exp, input string tag);
    vid_addr = a; vid_strobe = 1'b1;
    tick();
    vid_strobe = 1'b0;
    chk(tag, {24'd0, vid_data}, {24'd0, exp});
  endtask

  initial begin
    int k;
    int rv;
    int dn;
    int c;
    int w;

    reset = 1'b1; vid_addr = '0; vid_strobe = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; clear_start = 1'b0;
    repeat (3) tick();
    chk("rst_vid_data", {24'd0, vid_data}, 32'd0);
    chk("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
    chk("rst_busy", {31'd0, cpu_busy}, 32'd0);
    chk("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("rst_done", {31'd0, clear_done}, 32'd0);
    reset = 1'b0;
    tick();

    // Video fetch of a preloaded byte, then held
    cpu_write(11'h028, 8'h38);
    vid_read(11'h028, 8'h38, "vid_028");
    tick();
    chk("vid_hold", {24'd0, vid_data}, 32'h38);

    // CPU write then read, latency 2
    cpu_write(11'h100, 8'h5A);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h100;
    tick();
    cpu_req = 1'b0;
    chk("rd_rvalid_t1", {31'd0, cpu_rvalid}, 32'd0);
    chk("rd_busy_t1", {31'd0, cpu_busy}, 32'd1);
    tick();
    chk("rd_rvalid_t2", {31'd0, cpu_rvalid}, 32'd1);
    chk("rd_data_t2", {24'd0, cpu_rdata}, 32'h5A);
    chk("rd_busy_t2", {31'd0, cpu_busy}, 32'd0);
    tick();
    chk("rd_rvalid_off", {31'd0, cpu_rvalid}, 32'd0);
    chk("rd_data_hold", {24'd0, cpu_rdata}, 32'h5A);
    vid_read(11'h100, 8'h5A, "vid_100");

    // Contention: two video strobes delay the CPU read
    cpu_write(11'h200, 8'hC3);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h200;
    tick();
    cpu_req = 1'b0; vid_strobe = 1'b1; vid_addr = 11'h028;
    tick();
    chk("ct_vid_t2", {24'd0, vid_data}, 32'h38);
    chk("ct_rvalid_t2", {31'd0, cpu_rvalid}, 32'd0);
    vid_addr = 11'h100;
    tick();
    vid_strobe = 1'b0;
    chk("ct_vid_t3", {24'd0, vid_data}, 32'h5A);
    chk("ct_rvalid_t3", {31'd0, cpu_rvalid}, 32'd0);
    chk("ct_busy_t3", {31'd0, cpu_busy}, 32'd1);
    tick();
    chk("ct_rvalid_t4", {31'd0, cpu_rvalid}, 32'd1);
    chk("ct_data_t4", {24'd0, cpu_rdata}, 32'hC3);
    chk("ct_busy_t4", {31'd0, cpu_busy}, 32'd0);
    chk("ct_vid_t4", {24'd0, vid_data}, 32'h5A);

    // Second request while busy is ignored
    cpu_write(11'h300, 8'h11);
    cpu_write(11'h301, 8'h22);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h300; cpu_wdata = 8'h99;
    tick();
    cpu_addr = 11'h301; cpu_wdata = 8'h66;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    vid_read(11'h300, 8'h99, "ign_wr_first");
    vid_read(11'h301, 8'h22, "ign_wr_second");
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h300;
    tick();
    cpu_addr = 11'h301; vid_strobe = 1'b1; vid_addr = 11'h028;
    tick();
    cpu_req = 1'b0; vid_strobe = 1'b0;
    rv = 0;
    for (int i = 0; i < 5; i++) begin
      if (cpu_rvalid) begin
        rv++;
        chk("ign_rd_data", {24'd0, cpu_rdata}, 32'h99);
      end
      tick();
    end
    chk("ign_rd_count", rv, 32'd1);

    // Clear with idle video: done 2049 cycles after start
    cpu_write(11'h7FF, 8'hEE);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("clr_busy", {31'd0, cpu_busy}, 32'd1);
    k = 1;
    while (!clear_done && k < 4000) begin
      tick();
      k++;
    end
    chk("clr_latency", k, 32'd2049);
    chk("clr_busy_end", {31'd0, cpu_busy}, 32'd0);
    tick();
    chk("clr_done_pulse", {31'd0, clear_done}, 32'd0);
    vid_read(11'h000, 8'h00, "clr_000");
    vid_read(11'h028, 8'h00, "clr_028");
    vid_read(11'h100, 8'h00, "clr_100");
    vid_read(11'h300, 8'h00, "clr_300");
    vid_read(11'h7FF, 8'h00, "clr_7ff");

    // Clear with a video strobe every 8th cycle; each strobe steals one write slot
    c = 0; w = 0;
    while (w < 2048) begin
      c++;
      if (c % 8 != 0) w++;
    end
    cpu_write(11'h123, 8'hAB);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    k = 1;
    while (!clear_done && k < 4000) begin
      vid_strobe = (k % 8 == 0);
      vid_addr = 11'h7F0;
      tick();
      k++;
    end
    vid_strobe = 1'b0;
    chk("clr_vid_latency", k, c + 1);
    vid_read(11'h123, 8'h00, "clr_vid_123");

    // Reset in the middle of a clear with counter at 0x200
    cpu_write(11'h1FF, 8'h44);
    cpu_write(11'h200, 8'h55);
    cpu_write(11'h201, 8'h66);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (11'h200) tick();
    chk("mid_busy", {31'd0, cpu_busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, cpu_busy}, 32'd0);
    chk("abort_done", {31'd0, clear_done}, 32'd0);
    dn = 0;
    for (int i = 0; i < 2100; i++) begin
      if (clear_done) dn++;
      tick();
    end
    chk("abort_no_done", dn, 32'd0);
    vid_read(11'h000, 8'h00, "abort_000");
    vid_read(11'h1FF, 8'h00, "abort_1ff");
    vid_read(11'h200, 8'h55, "abort_200");
    vid_read(11'h201, 8'h66, "abort_201");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
